svc_rv_mmio_console: RTL and testbench

MMIO responder peripheral for the RV SoC's `io_*` port: the device end of the bus the core drives as initiator. It exposes a byte TX FIFO drained onto a valid/ready stream and a byte RX FIFO filled from a valid-only stream. CPU-visible status and overflow flags are included. Read timing matches `svc_mem_sram`, so it drops into the IO slot without changing the SoC.

---
 rtl/svc_rv_mmio_console.sv | 116 +++++++++++
 tb/tb_svc_rv_mmio_console.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_mmio_console.sv
// rtl/svc_rv_mmio_console.sv - MMIO console: byte TX/RX FIFOs behind an SRAM-timed register port
module svc_rv_mmio_console #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [2:0] REG_TX_DATA = 3'd0;
    localparam logic [2:0] REG_RX_DATA = 3'd1;
    localparam logic [2:0] REG_RX_POP  = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [31:0]   rdata_q, rdata_d;

    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push_req, tx_push, tx_pop;
    logic       rx_pop_req, rx_push, rx_pop;
    logic       ovf_clear;
    logic [7:0] rx_head;
    logic [31:0] status;

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem_q[tx_rptr_q];
    assign io_rdata = rdata_q;

    always_comb begin
        tx_full  = (tx_count_q == FULL_COUNT);
        tx_empty = (tx_count_q == '0);
        rx_full  = (rx_count_q == FULL_COUNT);
        rx_empty = (rx_count_q == '0);

        tx_push_req = io_wen && (io_waddr[4:2] == REG_TX_DATA) && io_wstrb[0];
        rx_pop_req  = io_wen && (io_waddr[4:2] == REG_RX_POP) && (io_wstrb != 4'b0);
        ovf_clear   = io_wen && (io_waddr[4:2] == REG_CTRL) && io_wstrb[0] && io_wdata[0];

        // A push into a full FIFO is only accepted when the same cycle frees a slot.
        tx_pop  = !tx_empty && tx_ready;
        tx_push = tx_push_req && (!tx_full || tx_pop);
        rx_pop  = rx_pop_req && !rx_empty;
        rx_push = rx_valid && (!rx_full || rx_pop);

        tx_wptr_d  = tx_wptr_q + AW'(tx_push);
        tx_rptr_d  = tx_rptr_q + AW'(tx_pop);
        tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_pop);
        rx_wptr_d  = rx_wptr_q + AW'(rx_push);
        rx_rptr_d  = rx_rptr_q + AW'(rx_pop);
        rx_count_d = rx_count_q + CW'(rx_push) - CW'(rx_pop);

        // A new overflow wins over a clear in the same cycle.
        tx_ovf_d = (tx_ovf_q && !ovf_clear) || (tx_push_req && !tx_push);
        rx_ovf_d = (rx_ovf_q && !ovf_clear) || (rx_valid && !rx_push);
    end

    always_comb begin
        rx_head = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
        status  = {8'h00, 8'(rx_count_q), 8'(tx_count_q), 2'b00,
                   rx_ovf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
        rdata_d = 32'h0;
        case (io_raddr[4:2])
            REG_RX_DATA: rdata_d = {!rx_empty, 23'h0, rx_head};
            REG_STATUS:  rdata_d = status;
            default:     rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= io_wdata[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_svc_rv_mmio_console.sv
// tb/tb_svc_rv_mmio_console.sv - self-checking bench for svc_rv_mmio_console against a queue model
module tb_svc_rv_mmio_console;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_raddr = 32'h0;
    logic [31:0] io_rdata;
    logic        io_wen = 1'b0;
    logic [31:0] io_waddr = 32'h0;
    logic [31:0] io_wdata = 32'h0;
    logic [3:0]  io_wstrb = 4'h0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h0;

    svc_rv_mmio_console #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .io_raddr(io_raddr), .io_rdata(io_rdata),
        .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    byte unsigned txq[$];
    byte unsigned rxq[$];
    bit           m_txovf, m_rxovf;
    logic [31:0]  exp_rdata;

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[4:2] == 3'd1 && rxq.size() != 0) r = {1'b1, 23'h0, rxq[0]};
        if (a[4:2] == 3'd3) begin
            r[0] = (txq.size() == DEPTH);
            r[1] = (txq.size() == 0);
            r[2] = (rxq.size() == DEPTH);
            r[3] = (rxq.size() == 0);
            r[4] = m_txovf;
            r[5] = m_rxovf;
            r[15:8]  = 8'(txq.size());
            r[23:16] = 8'(rxq.size());
        end
        return r;
    endfunction

    // Apply one clock of the current inputs to the model, then advance to the next negedge.
    task automatic step();
        bit wtx, wpop, wclr, tpop, rpop;
        exp_rdata = model_read(io_raddr);
        wtx  = io_wen && io_waddr[4:2] == 3'd0 && io_wstrb[0];
        wpop = io_wen && io_waddr[4:2] == 3'd2 && io_wstrb != 4'h0;
        wclr = io_wen && io_waddr[4:2] == 3'd4 && io_wstrb[0] && io_wdata[0];
        tpop = tx_ready && txq.size() != 0;
        rpop = wpop && rxq.size() != 0;
        if (wclr) begin m_txovf = 0; m_rxovf = 0; end
        if (tpop) void'(txq.pop_front());
        if (rpop) void'(rxq.pop_front());
        if (wtx) begin
            if (txq.size() < DEPTH) txq.push_back(io_wdata[7:0]);
            else m_txovf = 1;
        end
        if (rx_valid) begin
            if (rxq.size() < DEPTH) rxq.push_back(rx_data);
            else m_rxovf = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        io_wen = 1'b1; io_waddr = a; io_wdata = d; io_wstrb = s;
        step();
        io_wen = 1'b0; io_wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        io_raddr = a;
        step();
    endtask

    task automatic rx_inject(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic model_reset();
        txq.delete(); rxq.delete(); m_txovf = 0; m_rxovf = 0;
    endtask

    task automatic test_reset();
        tx_ready = 1'b0;
        wr(32'h0, 32'h55, 4'h1);
        wr(32'h0, 32'h66, 4'h1);
        rx_valid = 1'b1; rx_data = 8'h77; io_raddr = 32'hC;
        io_wen = 1'b1; io_waddr = 32'h0; io_wdata = 32'h88; io_wstrb = 4'hF;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        rx_valid = 1'b0; io_wen = 1'b0; io_wstrb = 4'h0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", io_rdata); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rd(32'hC);
        checks++; if (io_rdata !== 32'h0000_000A) begin errors++; $display("FAIL reset_status got=%h exp=0000000a", io_rdata); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid_after got=%b exp=0", tx_valid); end
        rd(32'h4);
        checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL reset_rx_data got=%h exp=00000000", io_rdata); end
    endtask

    task automatic test_tx_order();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(32'h0, 32'hABCD_0041 + i, 4'h1);
        rd(32'hC);
        checks++; if (io_rdata[15:8] !== 8'd3) begin errors++; $display("FAIL tx_order_count got=%0d exp=3", io_rdata[15:8]); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                errors++; $display("FAIL tx_order_data%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_order_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        byte unsigned sent[$];
        logic [7:0] b;
        tx_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            wr({$urandom} & 32'hFFFF_FFE0, {24'($urandom), b}, 4'h1 | 4'($urandom));
        end
        rd(32'hC);
        checks++;
        if (io_rdata[0] !== 1'b1 || io_rdata[4] !== 1'b1 || io_rdata[15:8] !== 8'd16) begin
            errors++; $display("FAIL tx_ovf_status got=%h exp full=1 ovf=1 count=16", io_rdata);
        end
        checks++; if (io_rdata !== exp_rdata) begin errors++; $display("FAIL tx_ovf_status_model got=%h exp=%h", io_rdata, exp_rdata); end
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== sent[i]) begin
                errors++; $display("FAIL tx_ovf_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, sent[i]);
            end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_ovf_drained got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
        wr(32'h10, 32'h1, 4'h1);
        rd(32'hC);
        checks++; if (io_rdata[4] !== 1'b0) begin errors++; $display("FAIL tx_ovf_clear got=%b exp=0", io_rdata[4]); end
    endtask

    task automatic test_full_push_pop();
        byte unsigned sent[$];
        logic [7:0] b;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom); sent.push_back(b); wr(32'h0, {24'h0, b}, 4'h1);
        end
        b = 8'($urandom); sent.push_back(b);
        tx_ready = 1'b1;
        wr(32'h0, {24'h0, b}, 4'h1);
        tx_ready = 1'b0;
        rd(32'hC);
        checks++;
        if (io_rdata[4] !== 1'b0 || io_rdata[15:8] !== 8'd16 || io_rdata[0] !== 1'b1) begin
            errors++; $display("FAIL full_push_pop_status got=%h exp ovf=0 count=16 full=1", io_rdata);
        end
        tx_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== sent[i]) begin
                errors++; $display("FAIL full_push_pop_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, sent[i]);
            end
            step();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx_wrap();
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 0; i < DEPTH; i++) rx_inject(8'(8'h10 + i));
            if (pass == 2) begin
                rx_inject(8'($urandom));
                rd(32'hC);
                checks++;
                if (io_rdata[5] !== 1'b1 || io_rdata[2] !== 1'b1) begin
                    errors++; $display("FAIL rx_ovf_status got=%h exp rx_ovf=1 rx_full=1", io_rdata);
                end
            end
            rd(32'h4);
            checks++; if (io_rdata !== 32'h8000_0010) begin errors++; $display("FAIL rx_head_p%0d got=%h exp=80000010", pass, io_rdata); end
            for (int i = 0; i < DEPTH; i++) begin
                rd(32'h4);
                checks++;
                if (io_rdata !== exp_rdata || io_rdata[7:0] !== 8'(8'h10 + i)) begin
                    errors++; $display("FAIL rx_order_p%0d_%0d got=%h exp=%h", pass, i, io_rdata, exp_rdata);
                end
                wr(32'h8, $urandom, 4'($urandom_range(1, 15)));
            end
        end
        wr(32'h8, 32'h0, 4'hF);
        rd(32'h4);
        checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL rx_final_data got=%h exp=00000000", io_rdata); end
        rd(32'hC);
        checks++; if (io_rdata[3] !== 1'b1) begin errors++; $display("FAIL rx_final_empty got=%b exp=1", io_rdata[3]); end
        wr(32'h10, 32'h1, 4'h1);
    endtask

    task automatic test_read_timing_alias();
        logic [7:0] cnt;
        tx_ready = 1'b0;
        wr(32'h0, 32'h1, 4'h1);
        wr(32'h0, 32'h2, 4'h1);
        rd(32'h2C);
        checks++; if (io_rdata !== exp_rdata || io_rdata[15:8] !== 8'd2) begin errors++; $display("FAIL alias_status got=%h exp=%h", io_rdata, exp_rdata); end
        cnt = 8'(txq.size());
        io_raddr = 32'hC;
        wr(32'h0, 32'h3, 4'h1);
        checks++; if (io_rdata[15:8] !== cnt) begin errors++; $display("FAIL same_cycle_old_count got=%0d exp=%0d", io_rdata[15:8], cnt); end
        rd(32'hC);
        checks++; if (io_rdata[15:8] !== 8'(cnt + 1)) begin errors++; $display("FAIL next_cycle_count got=%0d exp=%0d", io_rdata[15:8], cnt + 1); end
        for (int i = 0; i < 8; i++) begin
            if (i == 1 || i == 3) continue;
            rd({27'($urandom), 3'(i), 2'($urandom)});
            checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read%0d got=%h exp=00000000", i, io_rdata); end
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tx_ready = 1'b0;
    endtask

    task automatic test_random_traffic();
        logic [2:0] offs [5];
        offs[0] = 3'd0; offs[1] = 3'd1; offs[2] = 3'd2; offs[3] = 3'd3; offs[4] = 3'd4;
        for (int n = 0; n < 600; n++) begin
            io_raddr = {27'($urandom), 3'($urandom), 2'($urandom)};
            io_wen   = ($urandom_range(0, 2) != 0);
            io_waddr = {27'($urandom), offs[$urandom_range(0, 4)], 2'($urandom)};
            if (io_waddr[4:2] == 3'd4 && $urandom_range(0, 5) != 0) io_waddr[4:2] = 3'd0;
            io_wdata = $urandom;
            io_wstrb = 4'($urandom);
            tx_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : (n % 150 < 90 ? $urandom_range(0, 4) == 0 : 1'b1);
            rx_valid = ($urandom_range(0, 1) == 1);
            rx_data  = 8'($urandom);
            step();
            checks++; if (io_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata%0d got=%h exp=%h", n, io_rdata, exp_rdata); end
            checks++;
            if (tx_valid !== (txq.size() != 0) || (txq.size() != 0 && tx_data !== txq[0])) begin
                errors++; $display("FAIL rand_tx%0d got=%b/%h exp=%b/%h", n, tx_valid, tx_data, txq.size() != 0,
                                   txq.size() != 0 ? txq[0] : 8'h0);
            end
        end
        io_wen = 1'b0; io_wstrb = 4'h0; rx_valid = 1'b0; tx_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_full_push_pop();
        test_rx_wrap();
        test_read_timing_alias();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
